alu_share_arb: RTL and testbench

Shares one combinational 4-bit ALU (adder datapath with carry, overflow and zero flags) between several requesters. Accepts one operation at a time through per-requester valid/ready handshakes, chosen by round-robin. Drives the ALU from registered operands and returns the registered result and flags on a single response channel tagged with the requester index. Sits between the requesting units and the shared `adderNway`-class ALU instance.

---
 rtl/alu_share_arb.sv | 143 ++++++++++++++
 tb/tb_alu_share_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin front end that time-shares one combinational ALU between N_REQ requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP and returns a tagged, registered result.
module alu_share_arb #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned W     = 4,
  parameter int unsigned OPW   = 4,
  parameter int unsigned IDW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  input  logic [N_REQ*OPW-1:0] req_op,
  output logic [W-1:0]         alu_x,
  output logic [W-1:0]         alu_y,
  output logic [OPW-1:0]       alu_op,
  input  logic [W-1:0]         alu_s,
  input  logic                 alu_c,
  input  logic                 alu_o,
  input  logic                 alu_z,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [W-1:0]         resp_s,
  output logic                 resp_c,
  output logic                 resp_o,
  output logic                 resp_z,
  output logic                 busy,
  output logic [7:0]           done_cnt
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         r_state;
  logic [IDW-1:0] r_last;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [OPW-1:0] r_op;
  logic [IDW-1:0] r_resp_id;
  logic [W-1:0]   r_resp_s;
  logic           r_resp_c;
  logic           r_resp_o;
  logic           r_resp_z;
  logic [7:0]     r_done;

  logic           w_found;
  logic [IDW-1:0] w_gnt;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [OPW-1:0] w_op;

  // Rotating priority: the lowest valid index above r_last wins; otherwise the lowest at or
  // below it. Descending scans let the later (higher-priority) pass overwrite the first.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i] && (i <= int'(r_last))) begin
        w_found = 1'b1;
        w_gnt   = IDW'(i);
      end
    end
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(r_last))) begin
        w_found = 1'b1;
        w_gnt   = IDW'(i);
      end
    end
  end

  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_op      = '0;
    req_ready = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_found && (w_gnt == IDW'(i))) begin
        w_a          = req_a[i*W +: W];
        w_b          = req_b[i*W +: W];
        w_op         = req_op[i*OPW +: OPW];
        req_ready[i] = (r_state == StIdle);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_last    <= IDW'(N_REQ - 1);
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_resp_id <= '0;
      r_resp_s  <= '0;
      r_resp_c  <= 1'b0;
      r_resp_o  <= 1'b0;
      r_resp_z  <= 1'b0;
      r_done    <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_last  <= w_gnt;
            r_state <= StExec;
          end
        end
        StExec: begin
          r_resp_s  <= alu_s;
          r_resp_c  <= alu_c;
          r_resp_o  <= alu_o;
          r_resp_z  <= alu_z;
          r_resp_id <= r_last;
          r_state   <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            r_done  <= r_done + 8'd1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign alu_x      = r_a;
  assign alu_y      = r_b;
  assign alu_op     = r_op;
  assign resp_valid = (r_state == StResp);
  assign resp_id    = r_resp_id;
  assign resp_s     = r_resp_s;
  assign resp_c     = r_resp_c;
  assign resp_o     = r_resp_o;
  assign resp_z     = r_resp_z;
  assign busy       = (r_state != StIdle);
  assign done_cnt   = r_done;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with an add-only 4-bit ALU model.
module tb_alu_share_arb;
  localparam int N = 3, W = 4, OPW = 4, IDW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*OPW-1:0] req_op;
  logic [W-1:0]   alu_x, alu_y, alu_s;
  logic [OPW-1:0] alu_op;
  logic           alu_c, alu_o, alu_z;
  logic           resp_valid, resp_ready;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_s;
  logic           resp_c, resp_o, resp_z, busy;
  logic [7:0]     done_cnt;

  alu_share_arb #(.N_REQ(N), .W(W), .OPW(OPW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_s(alu_s), .alu_c(alu_c), .alu_o(alu_o), .alu_z(alu_z),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_s(resp_s), .resp_c(resp_c), .resp_o(resp_o), .resp_z(resp_z),
    .busy(busy), .done_cnt(done_cnt)
  );

  // Add-only ALU model
  assign {alu_c, alu_s} = {1'b0, alu_x} + {1'b0, alu_y};
  assign alu_o = (alu_x[W-1] == alu_y[W-1]) && (alu_s[W-1] != alu_x[W-1]);
  assign alu_z = (alu_s == '0);

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_done;

  typedef struct {
    int         id;
    logic [3:0] a, b, s;
    logic       c, o, z;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready(input int id, input string name);
    int n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, " ready"}, 32'(req_ready), 32'(1 << id));
  endtask

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_done = 8'd0;
  endtask

  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic c, input logic o, input logic z,
                        input string name, input bit full);
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_op[id*OPW +: OPW] = 4'h0;
    resp_ready = 1'b1;
    #1;
    wait_ready(id, name);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    if (full) begin
      chk({name, " exec busy"}, 32'(busy), 32'd1);
      chk({name, " exec resp_valid"}, 32'(resp_valid), 32'd0);
      chk({name, " alu_x"}, 32'(alu_x), 32'(a));
      chk({name, " alu_y"}, 32'(alu_y), 32'(b));
    end
    @(negedge clk); #1;
    if (full) begin
      chk({name, " resp_valid"}, 32'(resp_valid), 32'd1);
      chk({name, " resp_id"}, 32'(resp_id), 32'(id));
      chk({name, " resp_s"}, 32'(resp_s), 32'(s));
      chk({name, " resp_c"}, 32'(resp_c), 32'(c));
      chk({name, " resp_o"}, 32'(resp_o), 32'(o));
      chk({name, " resp_z"}, 32'(resp_z), 32'(z));
    end
    @(negedge clk); #1;
    exp_done = exp_done + 8'd1;
    chk({name, " done_cnt"}, 32'(done_cnt), 32'(exp_done));
    if (full) chk({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int gcount, last_cyc, cyc;

    vecs[0] = '{0, 4'd3,  4'd4,  4'd7,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 4'd7,  4'd1,  4'd8,  1'b0, 1'b1, 1'b0};
    vecs[2] = '{1, 4'd8,  4'd8,  4'd0,  1'b1, 1'b1, 1'b1};
    vecs[3] = '{2, 4'd15, 4'd1,  4'd0,  1'b1, 1'b0, 1'b1};
    vecs[4] = '{0, 4'd5,  4'd10, 4'd15, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2, 4'd12, 4'd4,  4'd0,  1'b1, 1'b0, 1'b1};
    vecs[6] = '{1, 4'd9,  4'd9,  4'd2,  1'b1, 1'b1, 1'b0};

    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
    rst_n = 1'b1;
    exp_done = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst alu_x", 32'(alu_x), 32'd0);
    chk("rst alu_y", 32'(alu_y), 32'd0);
    chk("rst alu_op", 32'(alu_op), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_id", 32'(resp_id), 32'd0);
    chk("rst resp_s", 32'(resp_s), 32'd0);
    chk("rst resp_flags", 32'({resp_c, resp_o, resp_z}), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].o, vecs[i].z,
             $sformatf("vec%0d", i), 1'b1);
    end

    // Round-robin with all requesters continuously valid
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 4'(i + 1);
      req_b[i*W +: W] = 4'd1;
    end
    req_valid  = '1;
    resp_ready = 1'b1;
    #1;
    gcount = 0; last_cyc = 0; cyc = 0;
    while (gcount < 6 && cyc < 60) begin
      if (req_ready != '0) begin
        chk($sformatf("rr grant%0d", gcount), 32'(req_ready), 32'(1 << (gcount % N)));
        if (gcount > 0) chk($sformatf("rr interval%0d", gcount), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        gcount++;
      end
      if (gcount < 6) begin
        @(negedge clk); #1;
        cyc++;
      end
    end
    chk("rr grant count", 32'(gcount), 32'd6);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("rr last resp_id", 32'(resp_id), 32'd2);
    chk("rr last resp_s", 32'(resp_s), 32'd4);
    @(negedge clk); #1;
    exp_done = 8'd6;
    chk("rr done_cnt", 32'(done_cnt), 32'(exp_done));

    // Response backpressure while requester 2 waits
    @(negedge clk);
    req_a[0 +: W] = 4'd1; req_b[0 +: W] = 4'd2;
    req_a[2*W +: W] = 4'd5; req_b[2*W +: W] = 4'd6;
    req_valid = 3'b101;
    resp_ready = 1'b0;
    #1;
    chk("bp first grant", 32'(req_ready), 32'b001);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d resp_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d resp", k), 32'({resp_id, resp_s, resp_c, resp_o, resp_z}),
          32'({3'd0, 4'd3, 1'b0, 1'b0, 1'b0}));
      chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d busy", k), 32'(busy), 32'd1);
      @(negedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    exp_done = exp_done + 8'd1;
    chk("bp req2 granted", 32'(req_ready), 32'b100);
    chk("bp done_cnt", 32'(done_cnt), 32'(exp_done));
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk); #1;
    chk("bp req2 resp", 32'({resp_valid, resp_id, resp_s, resp_c, resp_o, resp_z}),
        32'({1'b1, 3'd2, 4'd11, 1'b0, 1'b1, 1'b0}));
    @(negedge clk); #1;
    exp_done = exp_done + 8'd1;
    chk("bp req2 done_cnt", 32'(done_cnt), 32'(exp_done));

    // Reset while in EXEC
    @(negedge clk);
    req_a[W +: W] = 4'd2; req_b[W +: W] = 4'd2;
    req_valid[1] = 1'b1;
    #1;
    wait_ready(1, "mid-rst");
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    chk("mid-rst exec busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst resp_valid", 32'(resp_valid), 32'd0);
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst done_cnt", 32'(done_cnt), 32'd0);
    exp_done = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a[0 +: W] = 4'd1; req_b[0 +: W] = 4'd1;
    req_valid = '1;
    #1;
    chk("post-rst grant", 32'(req_ready), 32'b001);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("post-rst resp", 32'({resp_valid, resp_id, resp_s}), 32'({1'b1, 3'd0, 4'd2}));
    @(negedge clk); #1;
    exp_done = 8'd1;
    chk("post-rst done_cnt", 32'(done_cnt), 32'(exp_done));

    // done_cnt wrap after 256 completions
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_op(i % N, 4'(i), 4'd1, 4'(i + 1), 1'b0, 1'b0, 1'b0, $sformatf("wrap%0d", i), 1'b0);
    end
    chk("wrap done_cnt zero", 32'(done_cnt), 32'd0);
    run_op(1, 4'd6, 4'd6, 4'd12, 1'b0, 1'b1, 1'b0, "after-wrap", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
